// File: rtl/regfile_wb_ctrl_if.sv
// Purpose: bundles issue, writeback-request and register-file-write signals of regfile_wb_ctrl.
// Latency: none, wiring only.
// Backpressure: reqN_ready is driven by the slave (controller); master must hold valid/addr/data until ready.
interface regfile_wb_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  localparam int NREG = 1 << AWIDTH;

  // Issue-side reservation
  logic              iss_valid;
  logic [AWIDTH-1:0] iss_rd;

  // Writeback port 0 (ALU results)
  logic              req0_valid;
  logic              req0_ready;
  logic [AWIDTH-1:0] req0_addr;
  logic [DWIDTH-1:0] req0_data;

  // Writeback port 1 (load data)
  logic              req1_valid;
  logic              req1_ready;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH-1:0] req1_data;

  // Register file write port and scoreboard
  logic              RegWEn;
  logic [AWIDTH-1:0] AddrD;
  logic [DWIDTH-1:0] DataD;
  logic [NREG-1:0]   busy;

  // Requesters / issue logic / register file side
  modport master (
    output iss_valid, iss_rd,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  RegWEn, AddrD, DataD, busy
  );

  // Writeback controller side
  modport slave (
    input  iss_valid, iss_rd,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output RegWEn, AddrD, DataD, busy
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Purpose: arbitrates two writeback ports onto the register file write port and tracks pending destinations.
// Latency: transfer in cycle N drives RegWEn/AddrD/DataD in cycle N+1; busy bit reads clear in cycle N+2.
// Backpressure: output stage never stalls; the losing port sees ready=0 and holds. Optional macro WB_RR_ARB_EN selects round-robin (default: port 1 fixed priority).
module regfile_wb_ctrl #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_ctrl_if.slave  wb
);
  localparam int NREG = 1 << AWIDTH;

  logic              grant0;
  logic              grant1;
  logic              ready0;
  logic              ready1;
  logic              xfer;
  logic [AWIDTH-1:0] xferAddr;
  logic [DWIDTH-1:0] xferData;

  logic              regWEnQ;
  logic [AWIDTH-1:0] addrDQ;
  logic [DWIDTH-1:0] dataDQ;
  logic [NREG-1:0]   busyQ;
  logic [NREG-1:0]   setVec;
  logic [NREG-1:0]   clrVec;
  logic [NREG-1:0]   busyNext;

`ifdef WB_RR_ARB_EN
  // 1 = port 1 was granted most recently, so port 0 wins the next tie
  logic              lastGrant;
`endif

  // Pick at most one port; ties go to round-robin or to the load port
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (wb.req0_valid && wb.req1_valid) begin
`ifdef WB_RR_ARB_EN
      if (lastGrant) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
`else
      grant1 = 1'b1;
`endif
    end else begin
      grant0 = wb.req0_valid;
      grant1 = wb.req1_valid;
    end
  end

  // Nothing is accepted while reset is held, even though valid may be high
  assign ready0 = grant0 & rst;
  assign ready1 = grant1 & rst;
  assign wb.req0_ready = ready0;
  assign wb.req1_ready = ready1;

  assign xfer     = ready0 | ready1;
  assign xferAddr = ready1 ? wb.req1_addr : wb.req0_addr;
  assign xferData = ready1 ? wb.req1_data : wb.req0_data;

`ifdef WB_RR_ARB_EN
  // Remember the winner of the last completed transfer only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrant <= 1'b1;
    end else if (ready0) begin
      lastGrant <= 1'b0;
    end else if (ready1) begin
      lastGrant <= 1'b1;
    end
  end
`endif

  // Registered write port; x0 transfers load addr/data but never raise the enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWEnQ <= 1'b0;
      addrDQ  <= '0;
      dataDQ  <= '0;
    end else if (xfer) begin
      regWEnQ <= (xferAddr != '0);
      addrDQ  <= xferAddr;
      dataDQ  <= xferData;
    end else begin
      regWEnQ <= 1'b0;
    end
  end

  // Scoreboard next state: clear the register being written now, then apply new reservation so it wins
  always_comb begin
    setVec = '0;
    clrVec = '0;
    if (wb.iss_valid && (wb.iss_rd != '0)) begin
      setVec[wb.iss_rd] = 1'b1;
    end
    if (regWEnQ) begin
      clrVec[addrDQ] = 1'b1;
    end
    busyNext    = (busyQ & ~clrVec) | setVec;
    busyNext[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busyQ <= '0;
    end else begin
      busyQ <= busyNext;
    end
  end

  assign wb.RegWEn = regWEnQ;
  assign wb.AddrD  = addrDQ;
  assign wb.DataD  = dataDQ;
  assign wb.busy   = busyQ;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Purpose: directed self-checking bench for regfile_wb_ctrl (reset, single write, contention, x0, set/clear race, throughput).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: requesters hold valid/addr/data until their ready is seen.
module tb_regfile_wb_ctrl;
  logic clk;
  logic rst;
  int   nCmp;
  int   nErr;
  logic [4:0] expSeq [8];
  int   i0;
  int   i1;

  regfile_wb_ctrl_if #(.DWIDTH(32), .AWIDTH(5)) wb ();

  regfile_wb_ctrl #(.DWIDTH(32), .AWIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb.iss_valid  = 1'b0;
    wb.iss_rd     = 5'd0;
    wb.req0_valid = 1'b0;
    wb.req0_addr  = 5'd0;
    wb.req0_data  = 32'd0;
    wb.req1_valid = 1'b0;
    wb.req1_addr  = 5'd0;
    wb.req1_data  = 32'd0;
  endtask

  initial begin
    nCmp = 0;
    nErr = 0;
    idle();
    rst = 1'b1;

    // ---- reset asserted with a request pending ----
    wb.req0_valid = 1'b1;
    wb.req0_addr  = 5'd3;
    wb.req0_data  = 32'h55;
    #2 rst = 1'b0;
    #1;
    check("rst_wen",   64'(wb.RegWEn), 64'd0);
    check("rst_addr",  64'(wb.AddrD), 64'd0);
    check("rst_data",  64'(wb.DataD), 64'd0);
    check("rst_busy",  64'(wb.busy), 64'd0);
    check("rst_rdy0",  64'(wb.req0_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    check("rel_rdy0", 64'(wb.req0_ready), 64'd0);

    // ---- single write, reserved x5 ----
    @(negedge clk);                       // cycle 0
    wb.iss_valid = 1'b1;
    wb.iss_rd    = 5'd5;
    @(negedge clk);                       // cycle 1
    idle();
    check("busy5_c1", 64'(wb.busy[5]), 64'd1);
    @(negedge clk);                       // cycle 2
    check("busy5_c2", 64'(wb.busy[5]), 64'd1);
    @(negedge clk);                       // cycle 3
    check("busy5_c3", 64'(wb.busy[5]), 64'd1);
    wb.req0_valid = 1'b1;
    wb.req0_addr  = 5'd5;
    wb.req0_data  = 32'hDEADBEEF;
    #1;
    check("sw_rdy0", 64'(wb.req0_ready), 64'd1);
    check("sw_rdy1", 64'(wb.req1_ready), 64'd0);
    @(negedge clk);                       // cycle 4
    idle();
    check("sw_wen",   64'(wb.RegWEn), 64'd1);
    check("sw_addr",  64'(wb.AddrD), 64'd5);
    check("sw_data",  64'(wb.DataD), 64'hDEADBEEF);
    check("busy5_c4", 64'(wb.busy[5]), 64'd1);
    @(negedge clk);                       // cycle 5
    check("busy5_c5", 64'(wb.busy[5]), 64'd0);
    check("sw_wen_off", 64'(wb.RegWEn), 64'd0);
    check("sw_hold_addr", 64'(wb.AddrD), 64'd5);
    check("sw_hold_data", 64'(wb.DataD), 64'hDEADBEEF);
    wb.iss_valid = 1'b1;                  // reserve x9, stays pending
    wb.iss_rd    = 5'd9;

    // ---- x0 write on port 1, with an issue to x0 ----
    @(negedge clk);
    idle();
    wb.req1_valid = 1'b1;
    wb.req1_addr  = 5'd0;
    wb.req1_data  = 32'h1234;
    wb.iss_valid  = 1'b1;
    wb.iss_rd     = 5'd0;
    #1;
    check("x0_rdy1", 64'(wb.req1_ready), 64'd1);
    check("x0_rdy0", 64'(wb.req0_ready), 64'd0);
    @(negedge clk);
    idle();
    check("x0_wen",  64'(wb.RegWEn), 64'd0);
    check("x0_addr", 64'(wb.AddrD), 64'd0);
    check("x0_data", 64'(wb.DataD), 64'h1234);
    check("x0_busy", 64'(wb.busy), 64'h200);

    // ---- contention, port 1 was granted last ----
`ifdef WB_RR_ARB_EN
    expSeq = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
`else
    expSeq = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd1, 5'd2, 5'd3, 5'd4};
`endif
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      wb.req0_valid = (i0 < 4);
      wb.req0_addr  = 5'(1 + i0);
      wb.req0_data  = 32'(32'h100 + 1 + i0);
      wb.req1_valid = (i1 < 4);
      wb.req1_addr  = 5'(11 + i1);
      wb.req1_data  = 32'(32'h200 + 11 + i1);
      #1;
      check("ctn_rdy0", 64'(wb.req0_ready), 64'(expSeq[k] < 5'd10));
      check("ctn_rdy1", 64'(wb.req1_ready), 64'(expSeq[k] >= 5'd10));
      @(negedge clk);
      check("ctn_wen",  64'(wb.RegWEn), 64'd1);
      check("ctn_addr", 64'(wb.AddrD), 64'(expSeq[k]));
      check("ctn_data", 64'(wb.DataD),
            (expSeq[k] < 5'd10) ? 64'(32'h100 + 32'(expSeq[k])) : 64'(32'h200 + 32'(expSeq[k])));
      if (expSeq[k] < 5'd10) i0++; else i1++;
    end
    idle();
    @(negedge clk);
    check("ctn_idle_wen", 64'(wb.RegWEn), 64'd0);
    check("ctn_busy", 64'(wb.busy), 64'h200);

    // ---- same-edge set and clear on x7 ----
    wb.iss_valid = 1'b1;
    wb.iss_rd    = 5'd7;
    @(negedge clk);
    idle();
    check("sc_busy_set", 64'(wb.busy), 64'h280);
    wb.req0_valid = 1'b1;
    wb.req0_addr  = 5'd7;
    wb.req0_data  = 32'h77;
    @(negedge clk);
    idle();
    check("sc_wen",  64'(wb.RegWEn), 64'd1);
    check("sc_addr", 64'(wb.AddrD), 64'd7);
    wb.iss_valid = 1'b1;
    wb.iss_rd    = 5'd7;
    @(negedge clk);
    idle();
    check("sc_busy7", 64'(wb.busy[7]), 64'd1);
    check("sc_busy",  64'(wb.busy), 64'h280);

    // ---- back-to-back throughput on port 0 ----
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check("b2b_wen",  64'(wb.RegWEn), 64'd1);
        check("b2b_addr", 64'(wb.AddrD), 64'(16 + i - 1));
        check("b2b_data", 64'(wb.DataD), 64'(32'hA0 + 32'(i - 1)));
      end
      if (i < 8) begin
        wb.req0_valid = 1'b1;
        wb.req0_addr  = 5'(16 + i);
        wb.req0_data  = 32'(32'hA0 + i);
        #1;
        check("b2b_rdy0", 64'(wb.req0_ready), 64'd1);
      end else begin
        idle();
      end
      @(negedge clk);
    end
    check("b2b_end_wen", 64'(wb.RegWEn), 64'd0);
    check("b2b_busy", 64'(wb.busy), 64'h280);

    // ---- reset mid-operation ----
    wb.req0_valid = 1'b1;
    wb.req0_addr  = 5'd3;
    wb.req0_data  = 32'h33;
    @(negedge clk);
    check("mid_wen_pre", 64'(wb.RegWEn), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_wen",  64'(wb.RegWEn), 64'd0);
    check("mid_addr", 64'(wb.AddrD), 64'd0);
    check("mid_data", 64'(wb.DataD), 64'd0);
    check("mid_busy", 64'(wb.busy), 64'd0);
    check("mid_rdy0", 64'(wb.req0_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    check("mid_rel_rdy0", 64'(wb.req0_ready), 64'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Writeback controller for the 32-entry register file. It shares the register file's single write port between two writeback requesters: port 0 for ALU results and port 1 for load data. It drives the register file's `RegWEn`/`AddrD`/`DataD` from a registered output stage. It also keeps a busy scoreboard of destination registers with writes in flight, which issue logic uses for RAW hazard stalls.

## Interface
- `DWIDTH`, 32, data width; matches the register file.
- `AWIDTH`, 5, register address width; scoreboard has 2**AWIDTH bits.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `iss_valid`  in  1  an instruction is issued this cycle and reserves `iss_rd`.
- `iss_rd`  in  AWIDTH  destination register being reserved.
- `req0_valid`  in  1  ALU writeback request.
- `req0_ready`  out  1  port 0 granted this cycle (combinational).
- `req0_addr`  in  AWIDTH  port 0 destination.
- `req0_data`  in  DWIDTH  port 0 data.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as port 0, for load writeback.
- `RegWEn`  out  1  register file write enable (registered).
- `AddrD`  out  AWIDTH  register file write address (registered).
- `DataD`  out  DWIDTH  register file write data (registered).
- `busy`  out  2**AWIDTH  scoreboard; bit r = 1 means a write to xr is pending.

## Operation
- Handshake: a transfer on port p happens in a cycle where `reqp_valid` and `reqp_ready` are both 1.
  - At most one port is granted per cycle.
  - The output stage never stalls, so at least one write is accepted per cycle whenever any valid is high.
- `reqp_ready` depends only on the two valids and the arbitration state, never on `ready`. A requester must hold `valid`, `addr` and `data` stable until its transfer completes.
- Arbitration (round-robin, see Configuration):
  - Only one port valid: that port is granted.
  - Both ports valid: the port not granted most recently wins.
  - `last_grant` updates only on a completed transfer.
- Output stage, on a transfer with address a and data d:
  - Next cycle `RegWEn`=1 if a≠0, otherwise 0. The transfer is consumed silently; x0 is never written.
  - `AddrD`=a and `DataD`=d are loaded regardless of a.
  - With no transfer, `RegWEn`=0 and `AddrD`/`DataD` hold their previous values.
- Scoreboard, evaluated every edge:
  - Set bit `iss_rd` when `iss_valid`=1 and `iss_rd`≠0.
  - Clear bit `AddrD` when `RegWEn`=1, i.e. on the same edge the register file captures the write.
  - If one edge both sets and clears the same bit, set wins: the newer reservation stays pending.
  - `busy[0]` is always 0.
  - Issuing to an already-busy register leaves it busy. The scoreboard is a bitmap, not a count; issue logic must not issue a second write to a busy rd.
- A writeback that arrives without a prior reservation still writes the register file. Clearing an already-clear bit has no effect.

## Timing
- Reset (`rst`=0, asynchronous):
  - `RegWEn`=0, `AddrD`=0, `DataD`=0, `busy`=0.
  - `last_grant`=1, so port 0 wins the first tie.
  - All of this takes effect immediately, without waiting for a clock edge.
- Reset asserted mid-operation drops all in-flight writes and reservations. `reqp_ready` is 0 while reset is asserted.
- Latency: transfer in cycle N gives `RegWEn` high in cycle N+1. The register file holds the data after the N+1 edge. `busy` bit clears on the same edge and reads 0 in cycle N+2.
- Throughput: one write per cycle sustained. Under continuous contention the ports alternate grant every cycle.

## Configuration
- `WB_RR_ARB_EN` defined: round-robin arbitration as described above.
- `WB_RR_ARB_EN` not defined: fixed priority, port 1 (load) always wins ties. `last_grant` is not implemented. Port 0 can starve while port 1 stays valid.
- All other behaviour is identical in both builds.

## Test plan
- Reset: drive `rst`=0 mid-transfer, check at once that `RegWEn`=0, `AddrD`=0, `DataD`=0 and `busy`=0. Release reset; check `req0_ready`=0 while `req0_valid`=0.
- Single write: `iss_valid`=1, `iss_rd`=5 at cycle 0. `req0` (5, 0xDEADBEEF) at cycle 3.
  - Cycle 4: `RegWEn`=1, `AddrD`=5, `DataD`=0xDEADBEEF.
  - `busy[5]`=1 in cycles 1–4 and 0 in cycle 5.
- Contention: both ports valid for 4 cycles, port 0 addresses 1–4 and port 1 addresses 11–14.
  - Round-robin build: `AddrD` sequence 1, 11, 2, 12, …
  - Fixed-priority build: 11, 12, 13, 14, then 1, 2, 3, 4.
- x0 write: `req1` (0, 0x1234) → `req1_ready`=1, then `RegWEn`=0 on the next cycle; `busy` unchanged.
- Same-edge set/clear: a write to x7 commits (`RegWEn`=1, `AddrD`=7) on the same edge as `iss_valid`=1, `iss_rd`=7 → `busy[7]` remains 1.
- Back-to-back throughput: `req0` valid for 8 consecutive cycles → `RegWEn` high for 8 consecutive cycles, one cycle later, with matching addresses and data.
